// File: rtl/fetch_memory_interface.sv
// Fetch-side memory bridge: turns a one-cycle fetch strobe into a valid/ready
// read against variable-latency instruction memory and registers the result.
module fetch_memory_interface #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 64,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD       = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pc_in,
  input  logic                  fetch_req,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  error
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQUEST = 2'd1;
  localparam logic [1:0] WAIT    = 2'd2;
  localparam logic [1:0] DRAIN   = 2'd3;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic                  rv_q, rv_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  dv_q, dv_d;
  logic                  err_q, err_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  timeout;

  assign timeout = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rv_d    = rv_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    err_d   = err_q;
    // Saturating count; only meaningful while a transaction is in flight.
    cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        if (fetch_req) begin
          if (pc_in[1:0] != 2'b00) begin
            err_d  = 1'b1;
            data_d = NOP_WORD;
            dv_d   = 1'b1;
          end else begin
            addr_d  = pc_in;
            rv_d    = 1'b1;
            err_d   = 1'b0;
            cnt_d   = '0;
            state_d = REQUEST;
          end
        end
      end
      REQUEST: begin
        if (flush) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end else if (timeout) begin
          rv_d    = 1'b0;
          err_d   = 1'b1;
          data_d  = NOP_WORD;
          dv_d    = 1'b1;
          state_d = IDLE;
        end else if (mem_req_ready) begin
          rv_d    = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          // A response racing the flush is simply dropped.
          state_d = mem_rsp_valid ? IDLE : DRAIN;
        end else if (mem_rsp_valid) begin
          data_d  = mem_rsp_data;
          dv_d    = 1'b1;
          state_d = IDLE;
        end else if (timeout) begin
          err_d   = 1'b1;
          data_d  = NOP_WORD;
          dv_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        // DRAIN: the flushed transaction's response is swallowed; a timeout
        // here flags the error but the core already moved on, so no data pulse.
        if (mem_rsp_valid) begin
          state_d = IDLE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rv_q    <= 1'b0;
      data_q  <= NOP_WORD;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rv_q    <= rv_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_addr      = addr_q;
  assign mem_req_valid = rv_q;
  assign data_out      = data_q;
  assign data_valid    = dv_q;
  assign error         = err_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_fetch_memory_interface.sv
// Directed bench for fetch_memory_interface; short timeout to reach the abort path.
module tb_fetch_memory_interface;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        fetch_req;
  logic        flush;
  logic [31:0] mem_addr;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [31:0] data_out;
  logic        data_valid;
  logic        busy;
  logic        error;

  int checks = 0;
  int errors = 0;

  fetch_memory_interface #(
    .DATA_WIDTH(32), .TIMEOUT_CYCLES(8), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .fetch_req(fetch_req),
    .flush(flush), .mem_addr(mem_addr), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .data_out(data_out),
    .data_valid(data_valid), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"}, mem_addr, 32'h0);
    chk({tag, "_rv"}, 32'(mem_req_valid), 32'h0);
    chk({tag, "_data"}, data_out, NOP);
    chk({tag, "_dv"}, 32'(data_valid), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_err"}, 32'(error), 32'h0);
  endtask

  initial begin
    reset = 1'b1; pc_in = '0; fetch_req = 1'b0; flush = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    step(); step();
    reset = 1'b0;
    chk_reset("reset");

    // Aligned fetch against zero-wait memory
    pc_in = 32'h100; fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_rv", 32'(mem_req_valid), 32'h1);
    chk("t1_busy1", 32'(busy), 32'h1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("t1_rv_drop", 32'(mem_req_valid), 32'h0);
    chk("t1_busy2", 32'(busy), 32'h1);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h00500093;
    step();
    mem_rsp_valid = 1'b0;
    chk("t1_data", data_out, 32'h00500093);
    chk("t1_dv", 32'(data_valid), 32'h1);
    chk("t1_busy3", 32'(busy), 32'h0);
    step();
    chk("t1_dv_pulse", 32'(data_valid), 32'h0);
    chk("t1_hold", data_out, 32'h00500093);

    // Misaligned PC: no request, NOP and error
    pc_in = 32'h102; fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("t3_rv", 32'(mem_req_valid), 32'h0);
    chk("t3_busy", 32'(busy), 32'h0);
    chk("t3_err", 32'(error), 32'h1);
    chk("t3_data", data_out, NOP);
    chk("t3_dv", 32'(data_valid), 32'h1);
    step();
    chk("t3_err_sticky", 32'(error), 32'h1);
    chk("t3_dv_pulse", 32'(data_valid), 32'h0);

    // Backpressure: request held for 5 cycles of ready low
    pc_in = 32'h104; fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("t2_err_clr", 32'(error), 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t2_rv%0d", i), 32'(mem_req_valid), 32'h1);
      chk($sformatf("t2_addr%0d", i), mem_addr, 32'h104);
      pc_in = 32'h200;
      fetch_req = (i == 2);   // dropped while busy
      step();
    end
    fetch_req = 1'b0;
    chk("t2_rv_last", 32'(mem_req_valid), 32'h1);
    chk("t2_addr_last", mem_addr, 32'h104);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("t2_rv_drop", 32'(mem_req_valid), 32'h0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h00A00113;
    step();
    mem_rsp_valid = 1'b0;
    chk("t2_data", data_out, 32'h00A00113);
    chk("t2_dv", 32'(data_valid), 32'h1);
    step();
    chk("t2_idle", 32'(busy), 32'h0);

    // Flush one cycle after handshake, response arrives later and is dropped
    pc_in = 32'h108; fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t4_busy_drain", 32'(busy), 32'h1);
    step();
    step();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEADBEEF;
    chk("t4_busy_pre", 32'(busy), 32'h1);
    step();
    mem_rsp_valid = 1'b0;
    chk("t4_data", data_out, 32'h00A00113);
    chk("t4_dv", 32'(data_valid), 32'h0);
    chk("t4_busy", 32'(busy), 32'h0);

    // Timeout with TIMEOUT_CYCLES=8: outcome visible 8 cycles after issue
    pc_in = 32'h10C; fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      chk($sformatf("t5_wait_busy%0d", c), 32'(busy), 32'h1);
      chk($sformatf("t5_wait_dv%0d", c), 32'(data_valid), 32'h0);
      step();
    end
    chk("t5_err", 32'(error), 32'h1);
    chk("t5_data", data_out, NOP);
    chk("t5_dv", 32'(data_valid), 32'h1);
    chk("t5_busy", 32'(busy), 32'h0);
    pc_in = 32'h110; fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("t5_err_clr", 32'(error), 32'h0);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h00000073;
    step();
    mem_rsp_valid = 1'b0;
    chk("t5_good_data", data_out, 32'h00000073);
    chk("t5_good_dv", 32'(data_valid), 32'h1);

    // Reset mid-WAIT, stray response ignored, new fetch proceeds
    pc_in = 32'h114; fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset("t6_rst");
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h00000BAD;
    step();
    mem_rsp_valid = 1'b0;
    chk("t6_stray_dv", 32'(data_valid), 32'h0);
    chk("t6_stray_data", data_out, NOP);
    chk("t6_stray_busy", 32'(busy), 32'h0);
    pc_in = 32'h118; fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("t6_addr", mem_addr, 32'h118);
    chk("t6_rv", 32'(mem_req_valid), 32'h1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h00100093;
    step();
    mem_rsp_valid = 1'b0;
    chk("t6_data", data_out, 32'h00100093);
    chk("t6_dv", 32'(data_valid), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
